// File: rtl/servo_ctrl_multi.sv
// N-channel hobby-servo controller: per-channel slewed setpoint, PWM generation,
// at-target detection and latched over-current shutdown sharing one period counter.
module servo_ctrl_multi #(
  parameter int N_CH       = 4,
  parameter int ANG_W      = 8,
  parameter int ANG_MAX    = 180,
  parameter int CUR_W      = 10,
  parameter int PERIOD_CYC = 2000,
  parameter int PW_MIN     = 100,
  parameter int PW_STEP    = 1,
  parameter int SLEW_STEP  = 1,
  parameter int POS_TOL    = 2,
  parameter int I_LIMIT    = 512,
  parameter int FAULT_CNT  = 3,
  localparam int CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [CH_W-1:0]         cmd_ch,
  input  logic [ANG_W-1:0]        cmd_angle,
  input  logic [N_CH*CUR_W-1:0]   meas_current,
  input  logic [N_CH*ANG_W-1:0]   meas_angle,
  input  logic [N_CH-1:0]         fault_clr,
  output logic [N_CH-1:0]         pwm_out,
  output logic [N_CH*ANG_W-1:0]   cur_angle,
  output logic [N_CH-1:0]         at_target,
  output logic [N_CH-1:0]         fault,
  output logic                    period_start
);

  localparam int CNT_W = (PERIOD_CYC > 1) ? $clog2(PERIOD_CYC) : 1;
  localparam int PW_W  = ANG_W + 16;
  localparam int CMP_W = (PW_W > CNT_W) ? PW_W : CNT_W;
  localparam int OC_W  = $clog2(FAULT_CNT + 1);

  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             cnt_zero, cnt_last, cmd_fire;
  logic [ANG_W-1:0] cmd_angle_clamped;

  always_comb begin
    cnt_zero          = (cnt_reg == '0);
    cnt_last          = (cnt_reg == CNT_W'(PERIOD_CYC - 1));
    cnt_next          = cnt_last ? '0 : cnt_reg + 1'b1;
    cmd_fire          = cmd_valid && !rst;
    cmd_angle_clamped = (cmd_angle > ANG_W'(ANG_MAX)) ? ANG_W'(ANG_MAX) : cmd_angle;
  end

  assign cmd_ready    = !rst;
  assign period_start = !rst && cnt_zero;

  always_ff @(posedge clk) begin
    if (rst) cnt_reg <= '0;
    else     cnt_reg <= cnt_next;
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      logic [ANG_W-1:0] target_reg, target_next, sp_reg, sp_next;
      logic [ANG_W-1:0] gap, slew, meas, err;
      logic [PW_W-1:0]  pw_reg, pw_next;
      logic [OC_W-1:0]  oc_cnt_reg, oc_cnt_next;
      logic             oc_seen_reg, oc_seen_next, over, oc_any, trip;
      logic             fault_reg, fault_next, pwm_reg, pwm_next, at_tgt_reg, at_tgt_next;

      always_comb begin
        // Out-of-range cmd_ch never matches any gi, so such commands are dropped.
        target_next = target_reg;
        if (cmd_fire && cmd_ch == CH_W'(gi)) target_next = cmd_angle_clamped;

        gap  = (target_reg > sp_reg) ? target_reg - sp_reg : sp_reg - target_reg;
        slew = (gap > ANG_W'(SLEW_STEP)) ? ANG_W'(SLEW_STEP) : gap;
        sp_next = sp_reg;
        pw_next = pw_reg;
        if (cnt_zero && !fault_reg) begin
          sp_next = (target_reg > sp_reg) ? sp_reg + slew : sp_reg - slew;
          pw_next = PW_W'(PW_MIN) + PW_W'(sp_next) * PW_W'(PW_STEP);
        end

        over         = meas_current[gi*CUR_W +: CUR_W] > CUR_W'(I_LIMIT);
        oc_any       = oc_seen_reg || over;
        oc_seen_next = oc_any;
        oc_cnt_next  = oc_cnt_reg;
        trip         = 1'b0;
        if (cnt_last) begin
          oc_seen_next = 1'b0;
          if (oc_any) begin
            if (oc_cnt_reg < OC_W'(FAULT_CNT)) oc_cnt_next = oc_cnt_reg + 1'b1;
            trip = (oc_cnt_next == OC_W'(FAULT_CNT));
          end else begin
            oc_cnt_next = '0;
          end
        end

        // A trip in the same cycle as a clear keeps the channel faulted.
        fault_next = fault_reg;
        if (trip) begin
          fault_next = 1'b1;
        end else if (fault_clr[gi]) begin
          fault_next   = 1'b0;
          oc_cnt_next  = '0;
          oc_seen_next = 1'b0;
        end

        pwm_next = !fault_next && (cnt_next != '0) &&
                   (CMP_W'(cnt_next) <= CMP_W'(pw_next));

        meas        = meas_angle[gi*ANG_W +: ANG_W];
        err         = (meas > sp_reg) ? meas - sp_reg : sp_reg - meas;
        at_tgt_next = (sp_reg == target_reg) && (err <= ANG_W'(POS_TOL));
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          target_reg  <= '0;
          sp_reg      <= '0;
          pw_reg      <= '0;
          oc_cnt_reg  <= '0;
          oc_seen_reg <= 1'b0;
          fault_reg   <= 1'b0;
          pwm_reg     <= 1'b0;
          at_tgt_reg  <= 1'b0;
        end else begin
          target_reg  <= target_next;
          sp_reg      <= sp_next;
          pw_reg      <= pw_next;
          oc_cnt_reg  <= oc_cnt_next;
          oc_seen_reg <= oc_seen_next;
          fault_reg   <= fault_next;
          pwm_reg     <= pwm_next;
          at_tgt_reg  <= at_tgt_next;
        end
      end

      assign pwm_out[gi]                   = pwm_reg;
      assign cur_angle[gi*ANG_W +: ANG_W]  = sp_reg;
      assign at_target[gi]                 = at_tgt_reg;
      assign fault[gi]                     = fault_reg;
    end
  endgenerate

endmodule

// File: tb/tb_servo_ctrl_multi.sv
// Directed bench for servo_ctrl_multi: slewing, clamping, PWM widths, at_target,
// over-current fault latch/clear, and dropped out-of-range channel commands.
module tb_servo_ctrl_multi;
  localparam int N_CH  = 4;
  localparam int ANG_W = 8;
  localparam int CUR_W = 10;
  localparam int PER   = 400;
  localparam int NB    = 3;

  logic clk = 1'b0;
  logic rst;
  logic cmd_valid;
  logic [1:0] cmd_ch;
  logic [ANG_W-1:0] cmd_angle;
  logic [N_CH*CUR_W-1:0] meas_current;
  logic [N_CH*ANG_W-1:0] meas_angle;
  logic [N_CH-1:0] fault_clr;
  logic cmd_ready, period_start;
  logic [N_CH-1:0] pwm_out, at_target, fault;
  logic [N_CH*ANG_W-1:0] cur_angle;

  logic cmd_valid_b;
  logic [1:0] cmd_ch_b;
  logic [ANG_W-1:0] cmd_angle_b;
  logic [NB*CUR_W-1:0] meas_current_b;
  logic [NB*ANG_W-1:0] meas_angle_b;
  logic [NB-1:0] fault_clr_b;
  logic cmd_ready_b, period_start_b;
  logic [NB-1:0] pwm_out_b, at_target_b, fault_b;
  logic [NB*ANG_W-1:0] cur_angle_b;

  servo_ctrl_multi #(.N_CH(N_CH), .PERIOD_CYC(PER), .SLEW_STEP(10)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_ch(cmd_ch), .cmd_angle(cmd_angle), .meas_current(meas_current),
    .meas_angle(meas_angle), .fault_clr(fault_clr), .pwm_out(pwm_out),
    .cur_angle(cur_angle), .at_target(at_target), .fault(fault),
    .period_start(period_start)
  );

  // A 2-bit cmd_ch cannot carry 5, so the out-of-range drop is exercised on a 3-channel instance.
  servo_ctrl_multi #(.N_CH(NB), .PERIOD_CYC(PER), .SLEW_STEP(10)) dut_b (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid_b), .cmd_ready(cmd_ready_b),
    .cmd_ch(cmd_ch_b), .cmd_angle(cmd_angle_b), .meas_current(meas_current_b),
    .meas_angle(meas_angle_b), .fault_clr(fault_clr_b), .pwm_out(pwm_out_b),
    .cur_angle(cur_angle_b), .at_target(at_target_b), .fault(fault_b),
    .period_start(period_start_b)
  );

  always #5 clk = ~clk;

  int mcnt;
  always @(posedge clk) begin
    if (rst) mcnt <= 0;
    else     mcnt <= (mcnt == PER - 1) ? 0 : mcnt + 1;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic goto_cnt(input int c);
    for (int i = 0; i <= PER; i++) begin
      tick();
      if (mcnt == c) break;
    end
  endtask

  function automatic int amin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic set_cur3(input int v);
    meas_current[3*CUR_W +: CUR_W] = CUR_W'(v);
  endtask

  int pw_cnt[N_CH];
  int exp_ang[N_CH];
  int oc_tbl[6] = '{600, 600, 512, 600, 600, 600};

  initial begin
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_ch = '0; cmd_angle = '0;
    meas_current = '0; meas_angle = '0; fault_clr = '0;
    cmd_valid_b = 1'b0; cmd_ch_b = '0; cmd_angle_b = '0;
    meas_current_b = '0; meas_angle_b = '0; fault_clr_b = '0;

    repeat (5) @(posedge clk);
    @(negedge clk);
    check("rst pwm_out", pwm_out, 0);
    check("rst cur_angle", cur_angle, 0);
    check("rst at_target", at_target, 0);
    check("rst fault", fault, 0);
    check("rst period_start", period_start, 0);
    check("rst cmd_ready", cmd_ready, 0);
    rst = 1'b0;
    #1;
    check("release period_start", period_start, 1);
    check("release cmd_ready", cmd_ready, 1);
    $display("reset released");

    tick();
    check("cnt1 period_start", period_start, 0);
    cmd_valid = 1'b1; cmd_ch = 2'd1; cmd_angle = 8'd90;
    cmd_valid_b = 1'b1; cmd_ch_b = 2'd3; cmd_angle_b = 8'd77;
    tick();
    cmd_ch = 2'd0; cmd_angle = 8'd250; cmd_valid_b = 1'b0;
    tick();
    cmd_valid = 1'b0;
    $display("commands: ch1=90 ch0=250 (b: ch3=77)");

    goto_cnt(1);
    for (int k = 1; k <= 18; k++) begin
      exp_ang[0] = amin(10 * k, 180);
      exp_ang[1] = amin(10 * k, 90);
      exp_ang[2] = (k <= 5) ? 0 : amin(10 * (k - 5), 45);
      exp_ang[3] = 0;
      for (int ch = 0; ch < N_CH; ch++) begin
        check($sformatf("angle ch%0d p%0d", ch, k), cur_angle[ch*ANG_W +: ANG_W], exp_ang[ch]);
        pw_cnt[ch] = 0;
      end
      for (int c = 0; c < PER; c++) begin
        for (int ch = 0; ch < N_CH; ch++) if (pwm_out[ch]) pw_cnt[ch]++;
        if (k == 5 && mcnt == 50) begin
          cmd_valid = 1'b1; cmd_ch = 2'd2; cmd_angle = 8'd45;
        end else begin
          cmd_valid = 1'b0;
        end
        tick();
      end
      for (int ch = 0; ch < N_CH; ch++)
        check($sformatf("pw ch%0d p%0d", ch, k), pw_cnt[ch], 100 + exp_ang[ch]);
      $display("period %0d: angle=%0d/%0d/%0d/%0d pw=%0d/%0d/%0d/%0d", k,
               cur_angle[7:0], cur_angle[15:8], cur_angle[23:16], cur_angle[31:24],
               pw_cnt[0], pw_cnt[1], pw_cnt[2], pw_cnt[3]);
    end

    check("b dropped cur_angle", cur_angle_b, 0);
    check("b dropped at_target", at_target_b, 3'b111);
    check("b cmd_ready", cmd_ready_b, 1);
    $display("out-of-range command: cur_angle_b=%0d at_target_b=%b", cur_angle_b, at_target_b);

    check("at1 far", at_target[1], 0);
    meas_angle[15:8] = 8'd89; meas_angle[7:0] = 8'd178;
    tick();
    check("at1 meas89", at_target[1], 1);
    check("at0 meas178", at_target[0], 1);
    meas_angle[15:8] = 8'd87; meas_angle[7:0] = 8'd183;
    tick();
    check("at1 meas87", at_target[1], 0);
    check("at0 meas183", at_target[0], 0);
    meas_angle[15:8] = 8'd92;
    tick();
    check("at1 meas92", at_target[1], 1);
    meas_angle[15:8] = 8'd90;
    cmd_valid = 1'b1; cmd_ch = 2'd1; cmd_angle = 8'd100;
    tick();
    cmd_valid = 1'b0;
    tick();
    check("at1 target moved", at_target[1], 0);
    $display("at_target checks done");

    goto_cnt(0);
    for (int p = 0; p < 6; p++) begin
      set_cur3(oc_tbl[p]);
      goto_cnt(0);
      check($sformatf("fault3 after oc period %0d", p), fault[3], (p == 5) ? 1 : 0);
      $display("oc period %0d current=%0d fault=%b", p, oc_tbl[p], fault);
    end
    check("pwm3 at trip", pwm_out[3], 0);
    set_cur3(300);
    tick();
    check("pwm3 faulted", pwm_out[3], 0);
    check("pwm2 independent", pwm_out[2], 1);
    check("fault others", fault[2:0], 0);

    cmd_valid = 1'b1; cmd_ch = 2'd3; cmd_angle = 8'd20;
    tick();
    cmd_valid = 1'b0;
    goto_cnt(1);
    check("ang3 frozen", cur_angle[31:24], 0);
    check("fault3 held", fault[3], 1);
    check("pwm3 held off", pwm_out[3], 0);
    fault_clr = 4'b1000;
    tick();
    fault_clr = '0;
    check("fault3 cleared", fault[3], 0);
    goto_cnt(1);
    check("ang3 resumed", cur_angle[31:24], 10);
    check("pwm3 resumed", pwm_out[3], 1);
    $display("fault clear: fault=%b angle3=%0d", fault, cur_angle[31:24]);

    goto_cnt(0);
    set_cur3(600);
    goto_cnt(0);
    goto_cnt(0);
    goto_cnt(PER - 1);
    check("fault3 before trip", fault[3], 0);
    fault_clr = 4'b1000;
    tick();
    fault_clr = '0;
    check("fault3 set beats clr", fault[3], 1);
    check("pwm3 set beats clr", pwm_out[3], 0);
    set_cur3(300);
    $display("trip with clear: fault=%b", fault);

    goto_cnt(10);
    check("pwm0 mid pulse", pwm_out[0], 1);
    rst = 1'b1;
    tick();
    check("midrst pwm_out", pwm_out, 0);
    check("midrst fault", fault, 0);
    check("midrst cur_angle", cur_angle, 0);
    check("midrst cmd_ready", cmd_ready, 0);
    rst = 1'b0;
    $display("mid-period reset: pwm_out=%b", pwm_out);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
